if_fetch_stage: RTL and testbench
=================================

IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'hBFC00000, PC loaded at reset.
REQ-002 clk  input  1  sole clock, rising-edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 stall  input  1  IF/ID hold request from the PC/branch control block (its if_stall).
REQ-005 flush  input  1  IF/ID squash request (its if_rst).
REQ-006 redirect  input  1  PC redirect valid (its if_change1).
REQ-007 redirect_pc  input  32  next-PC target (its address_out).
REQ-008 inst_req  output  1  instruction-memory request.
REQ-009 inst_addr  output  32  word-aligned fetch address.
REQ-010 inst_ack  input  1  single-cycle read-done pulse.
REQ-011 inst_rdata  input  32  instruction data, valid with inst_ack.
REQ-012 id_valid  output  1  IF/ID slot holds a real instruction.
REQ-013 id_pc  output  32  PC of the ID-stage instruction.
REQ-014 id_pc4  output  32  id_pc+4; this is the address_in operand of the PC/branch control block.
REQ-015 id_inst  output  32  ID-stage instruction word.
REQ-016 perf_fetch, perf_bubble  output  32 each  performance counters (present only under REQ-033).

Function
REQ-017 The FSM SHALL have three states: REQ (fetch outstanding), DROP (outstanding fetch to be discarded), and HOLD (fetched word buffered while stalled).
REQ-018 inst_req and inst_addr SHALL be registered: inst_req=1 in REQ/DROP, 0 in HOLD, and inst_addr stable from assertion until inst_ack.
REQ-019 In REQ with inst_ack, no redirect, and no stall: load IF/ID {pc, pc+4, inst_rdata}, set id_valid=1, set pc<=pc+4, and stay in REQ, giving one instruction per cycle with zero-wait memory.
REQ-020 In REQ with inst_ack, stall, and no redirect: capture inst_rdata into the hold buffer, go to HOLD, hold IF/ID, and leave pc unchanged.
REQ-021 In HOLD with stall released: load IF/ID from the buffer, set pc<=pc+4, and go to REQ.
REQ-022 redirect with inst_ack in the same cycle (REQ): discard inst_rdata, set pc<=redirect_pc, and stay in REQ.
REQ-023 redirect without inst_ack (REQ): latch pend_pc<=redirect_pc and go to DROP; inst_addr is unchanged.
REQ-024 In DROP, a further redirect SHALL overwrite pend_pc, so the latest target wins; on inst_ack, discard the data, set pc<=pend_pc, and go to REQ.
REQ-025 redirect in HOLD: discard the buffer, set pc<=redirect_pc, and go to REQ.
REQ-026 redirect_pc[1:0] SHALL be ignored and the PC forced to a word boundary.
REQ-027 IF/ID update priority SHALL be flush > stall > load > bubble; flush clears id_valid even when stall is set.
REQ-028 A cycle with no deliverable instruction and no stall SHALL write id_valid=0 (bubble); id_pc, id_pc4, and id_inst are don't-care when id_valid=0.
REQ-029 pc+4 SHALL wrap modulo 2^32 (32'hFFFFFFFC -> 32'h00000000).
REQ-030 inst_ack while inst_req=0 SHALL be ignored.

Reset
REQ-031 While rst_n=0: pc=RESET_PC, state=REQ, inst_req=0, inst_addr=RESET_PC, id_valid=0, id_pc/id_pc4/id_inst=0, pend_pc=0, counters=0.
REQ-032 inst_req SHALL rise on the first rising clk edge after rst_n deasserts; reset asserted mid-fetch SHALL abandon the fetch with no IF/ID update.

Configuration
REQ-033 With IF_PERF_CNT_EN defined: perf_fetch increments on each IF/ID load, and perf_bubble increments on each cycle in which id_valid is written 0; both wrap at 2^32. Without it, both ports SHALL be tied to 0 and no counter flops are synthesised.

Verification
REQ-034 Reset release, inst_ack every cycle with rdata=0x24080001,0x24090002 -> inst_addr BFC00000,BFC00004; id_pc BFC00000 then BFC00004, id_pc4 BFC00004 then BFC00008, id_valid=1.
REQ-035 stall=1 for 3 cycles arriving with inst_ack at pc=BFC00008 -> inst_req=0 during HOLD, IF/ID frozen; on release id_pc=BFC00008 and inst_addr=BFC0000C.
REQ-036 redirect=1, redirect_pc=0x80000102, flush=1, no ack; ack 2 cycles later -> data dropped, id_valid=0, next inst_addr=0x80000100.
REQ-037 Two redirects in DROP (0x100, then 0x200) -> fetch resumes at 0x200 only.
REQ-038 pc=0xFFFFFFFC fetched -> id_pc4=0, next inst_addr=0; separately, flush+stall together -> id_valid=0.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: drives the instruction-memory request and fills the IF/ID register.
// Define IF_PERF_CNT_EN to build the fetch/bubble performance counters; otherwise both ports read 0.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_ack,
    input  logic [31:0] inst_rdata,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic [31:0] id_inst,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_bubble
);

    typedef enum logic [1:0] {ST_REQ, ST_DROP, ST_HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic [31:0] hold_buf_q, hold_buf_d;
    logic        inst_req_q, inst_req_d;
    logic [31:0] inst_addr_q, inst_addr_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic [31:0] id_inst_q, id_inst_d;

    logic        ack_v;
    logic [31:0] target_pc;
    logic        deliver;
    logic [31:0] deliver_inst;

    // An acknowledge is only meaningful while a request is actually outstanding.
    assign ack_v     = inst_ack & inst_req_q;
    assign target_pc = {redirect_pc[31:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_REQ: begin
                if (redirect) begin
                    state_d = ack_v ? ST_REQ : ST_DROP;
                end else if (ack_v && stall) begin
                    state_d = ST_HOLD;
                end
            end
            ST_DROP: begin
                if (ack_v) begin
                    state_d = ST_REQ;
                end
            end
            ST_HOLD: begin
                if (redirect || !stall) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_REQ;
        endcase
    end

    always_comb begin
        pc_d         = pc_q;
        pend_pc_d    = pend_pc_q;
        hold_buf_d   = hold_buf_q;
        deliver      = 1'b0;
        deliver_inst = inst_rdata;
        case (state_q)
            ST_REQ: begin
                if (redirect) begin
                    if (ack_v) begin
                        pc_d = target_pc;
                    end else begin
                        pend_pc_d = target_pc;
                    end
                end else if (ack_v) begin
                    if (stall) begin
                        hold_buf_d = inst_rdata;
                    end else begin
                        deliver = 1'b1;
                        pc_d    = pc_q + 32'd4;
                    end
                end
            end
            ST_DROP: begin
                // A redirect arriving alongside the ack is newer than pend_pc.
                if (redirect) begin
                    pend_pc_d = target_pc;
                end
                if (ack_v) begin
                    pc_d = redirect ? target_pc : pend_pc_q;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    pc_d = target_pc;
                end else if (!stall) begin
                    deliver      = 1'b1;
                    deliver_inst = hold_buf_q;
                    pc_d         = pc_q + 32'd4;
                end
            end
            default: ;
        endcase

        inst_req_d  = (state_d != ST_HOLD);
        inst_addr_d = pc_d;

        id_valid_d = id_valid_q;
        id_pc_d    = id_pc_q;
        id_pc4_d   = id_pc4_q;
        id_inst_d  = id_inst_q;
        if (flush) begin
            id_valid_d = 1'b0;
        end else if (stall) begin
            id_valid_d = id_valid_q;
        end else if (deliver) begin
            id_valid_d = 1'b1;
            id_pc_d    = pc_q;
            id_pc4_d   = pc_q + 32'd4;
            id_inst_d  = deliver_inst;
        end else begin
            id_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            pend_pc_q   <= 32'd0;
            inst_req_q  <= 1'b0;
            inst_addr_q <= RESET_PC;
            id_valid_q  <= 1'b0;
            id_pc_q     <= 32'd0;
            id_pc4_q    <= 32'd0;
            id_inst_q   <= 32'd0;
        end else begin
            pc_q        <= pc_d;
            pend_pc_q   <= pend_pc_d;
            inst_req_q  <= inst_req_d;
            inst_addr_q <= inst_addr_d;
            id_valid_q  <= id_valid_d;
            id_pc_q     <= id_pc_d;
            id_pc4_q    <= id_pc4_d;
            id_inst_q   <= id_inst_d;
        end
    end

    // The hold buffer is only read after being written in the same fetch, so it needs no reset.
    always_ff @(posedge clk) begin
        hold_buf_q <= hold_buf_d;
    end

    assign inst_req  = inst_req_q;
    assign inst_addr = inst_addr_q;
    assign id_valid  = id_valid_q;
    assign id_pc     = id_pc_q;
    assign id_pc4    = id_pc4_q;
    assign id_inst   = id_inst_q;

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_bubble_q, perf_bubble_d;

    always_comb begin
        perf_fetch_d  = perf_fetch_q;
        perf_bubble_d = perf_bubble_q;
        if (!flush && !stall && deliver) begin
            perf_fetch_d = perf_fetch_q + 32'd1;
        end
        if (flush || (!stall && !deliver)) begin
            perf_bubble_d = perf_bubble_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_q  <= 32'd0;
            perf_bubble_q <= 32'd0;
        end else begin
            perf_fetch_q  <= perf_fetch_d;
            perf_bubble_q <= perf_bubble_d;
        end
    end

    assign perf_fetch  = perf_fetch_q;
    assign perf_bubble = perf_bubble_q;
`else
    assign perf_fetch  = 32'd0;
    assign perf_bubble = 32'd0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios followed by a randomized run against a
// program-order reference model (next expected fetch PC, memory contents as a function of address).
module tb_if_fetch_stage;

    localparam logic [31:0] RST_PC = 32'hBFC00000;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_ack;
    logic [31:0] inst_rdata;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic [31:0] id_inst;
    logic [31:0] perf_fetch;
    logic [31:0] perf_bubble;

    int checks = 0;
    int errors = 0;

    if_fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_ack(inst_ack), .inst_rdata(inst_rdata),
        .id_valid(id_valid), .id_pc(id_pc), .id_pc4(id_pc4), .id_inst(id_inst),
        .perf_fetch(perf_fetch), .perf_bubble(perf_bubble)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h13579BDF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        inst_ack = 1'b1; inst_rdata = 32'h24080001;
        tick(); tick();
        checks++; if (inst_req !== 1'b0) begin errors++; $display("FAIL rst_inst_req got %b exp 0", inst_req); end
        checks++; if (inst_addr !== RST_PC) begin errors++; $display("FAIL rst_inst_addr got %h exp %h", inst_addr, RST_PC); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rst_id_valid got %b exp 0", id_valid); end
        checks++; if ({id_pc, id_pc4, id_inst} !== 96'd0) begin errors++; $display("FAIL rst_id_regs got %h %h %h exp 0", id_pc, id_pc4, id_inst); end
        checks++; if ({perf_fetch, perf_bubble} !== 64'd0) begin errors++; $display("FAIL rst_perf got %h %h exp 0", perf_fetch, perf_bubble); end
        @(negedge clk) rst_n = 1'b1;
        tick();
        checks++; if (inst_req !== 1'b1) begin errors++; $display("FAIL rel_inst_req got %b exp 1", inst_req); end
        checks++; if (inst_addr !== RST_PC) begin errors++; $display("FAIL rel_inst_addr got %h exp %h", inst_addr, RST_PC); end
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rel_ack_ignored got %b exp 0", id_valid); end
    endtask

    task automatic test_sequential();
        tick();
        checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL seq0_valid got %b exp 1", id_valid); end
        checks++; if (id_pc !== 32'hBFC00000) begin errors++; $display("FAIL seq0_pc got %h exp BFC00000", id_pc); end
        checks++; if (id_pc4 !== 32'hBFC00004) begin errors++; $display("FAIL seq0_pc4 got %h exp BFC00004", id_pc4); end
        checks++; if (id_inst !== 32'h24080001) begin errors++; $display("FAIL seq0_inst got %h exp 24080001", id_inst); end
        checks++; if (inst_addr !== 32'hBFC00004) begin errors++; $display("FAIL seq0_addr got %h exp BFC00004", inst_addr); end
        inst_rdata = 32'h24090002;
        tick();
        checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL seq1_valid got %b exp 1", id_valid); end
        checks++; if (id_pc !== 32'hBFC00004) begin errors++; $display("FAIL seq1_pc got %h exp BFC00004", id_pc); end
        checks++; if (id_pc4 !== 32'hBFC00008) begin errors++; $display("FAIL seq1_pc4 got %h exp BFC00008", id_pc4); end
        checks++; if (id_inst !== 32'h24090002) begin errors++; $display("FAIL seq1_inst got %h exp 24090002", id_inst); end
        checks++; if (inst_addr !== 32'hBFC00008) begin errors++; $display("FAIL seq1_addr got %h exp BFC00008", inst_addr); end
    endtask

    task automatic test_stall();
        stall = 1'b1; inst_ack = 1'b1; inst_rdata = 32'h2408000A;
        tick();
        checks++; if (inst_req !== 1'b0) begin errors++; $display("FAIL stall_req got %b exp 0", inst_req); end
        checks++; if (id_pc !== 32'hBFC00004 || id_valid !== 1'b1) begin errors++; $display("FAIL stall_frozen got %h/%b exp BFC00004/1", id_pc, id_valid); end
        inst_rdata = 32'hDEADBEEF;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (inst_req !== 1'b0) begin errors++; $display("FAIL hold_req got %b exp 0", inst_req); end
            checks++; if (inst_addr !== 32'hBFC00008) begin errors++; $display("FAIL hold_addr got %h exp BFC00008", inst_addr); end
            checks++; if (id_pc !== 32'hBFC00004 || id_inst !== 32'h24090002) begin errors++; $display("FAIL hold_frozen got %h %h exp BFC00004 24090002", id_pc, id_inst); end
        end
        stall = 1'b0; inst_ack = 1'b0;
        tick();
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'hBFC00008) begin errors++; $display("FAIL unstall_pc got %h/%b exp BFC00008/1", id_pc, id_valid); end
        checks++; if (id_inst !== 32'h2408000A) begin errors++; $display("FAIL unstall_inst got %h exp 2408000A", id_inst); end
        checks++; if (inst_addr !== 32'hBFC0000C || inst_req !== 1'b1) begin errors++; $display("FAIL unstall_addr got %h/%b exp BFC0000C/1", inst_addr, inst_req); end
    endtask

    task automatic test_redirect_drop();
        redirect = 1'b1; redirect_pc = 32'h80000102; flush = 1'b1; inst_ack = 1'b0;
        tick();
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL drop_flush_valid got %b exp 0", id_valid); end
        checks++; if (inst_addr !== 32'hBFC0000C || inst_req !== 1'b1) begin errors++; $display("FAIL drop_addr_kept got %h/%b exp BFC0000C/1", inst_addr, inst_req); end
        redirect = 1'b0; flush = 1'b0;
        tick();
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL drop_wait_valid got %b exp 0", id_valid); end
        inst_ack = 1'b1; inst_rdata = 32'h11111111;
        tick();
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL drop_data_discard got %b exp 0", id_valid); end
        checks++; if (inst_addr !== 32'h80000100) begin errors++; $display("FAIL drop_new_addr got %h exp 80000100", inst_addr); end
        inst_rdata = 32'h3C1D8000;
        tick();
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'h80000100 || id_inst !== 32'h3C1D8000) begin errors++; $display("FAIL drop_first_fetch got %b %h %h exp 1 80000100 3C1D8000", id_valid, id_pc, id_inst); end
    endtask

    task automatic test_double_redirect();
        inst_ack = 1'b0; redirect = 1'b1; redirect_pc = 32'h00000100;
        tick();
        redirect_pc = 32'h00000200;
        tick();
        checks++; if (inst_addr !== 32'h80000104) begin errors++; $display("FAIL dbl_addr_kept got %h exp 80000104", inst_addr); end
        redirect = 1'b0; inst_ack = 1'b1; inst_rdata = 32'h22222222;
        tick();
        checks++; if (inst_addr !== 32'h00000200 || id_valid !== 1'b0) begin errors++; $display("FAIL dbl_latest_wins got %h/%b exp 00000200/0", inst_addr, id_valid); end
        inst_rdata = 32'h33333333;
        tick();
        checks++; if (id_pc !== 32'h00000200 || id_inst !== 32'h33333333 || id_valid !== 1'b1) begin errors++; $display("FAIL dbl_fetch got %h %h %b exp 00000200 33333333 1", id_pc, id_inst, id_valid); end
    endtask

    task automatic test_wrap_and_flush_stall();
        redirect = 1'b1; redirect_pc = 32'hFFFFFFFE; inst_ack = 1'b1; inst_rdata = 32'h99999999;
        tick();
        checks++; if (inst_addr !== 32'hFFFFFFFC || id_valid !== 1'b0) begin errors++; $display("FAIL wrap_redirect_ack got %h/%b exp FFFFFFFC/0", inst_addr, id_valid); end
        redirect = 1'b0; inst_rdata = 32'h44444444;
        tick();
        checks++; if (id_pc !== 32'hFFFFFFFC || id_pc4 !== 32'h00000000) begin errors++; $display("FAIL wrap_pc4 got %h %h exp FFFFFFFC 00000000", id_pc, id_pc4); end
        checks++; if (inst_addr !== 32'h00000000) begin errors++; $display("FAIL wrap_addr got %h exp 00000000", inst_addr); end
        flush = 1'b1; stall = 1'b1; inst_rdata = 32'h55555555;
        tick();
        checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL flush_over_stall got %b exp 0", id_valid); end
        flush = 1'b0; stall = 1'b0; inst_ack = 1'b0;
        tick();
        checks++; if (id_valid !== 1'b1 || id_pc !== 32'd0 || id_inst !== 32'h55555555 || inst_addr !== 32'd4) begin errors++; $display("FAIL wrap_resume got %b %h %h %h exp 1 0 55555555 4", id_valid, id_pc, id_inst, inst_addr); end
    endtask

    task automatic test_reset_midfetch();
        inst_ack = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (inst_req !== 1'b0 || inst_addr !== RST_PC) begin errors++; $display("FAIL async_rst_req got %b %h exp 0 %h", inst_req, inst_addr, RST_PC); end
        checks++; if (id_valid !== 1'b0 || id_pc !== 32'd0) begin errors++; $display("FAIL async_rst_id got %b %h exp 0 0", id_valid, id_pc); end
        inst_ack = 1'b1; inst_rdata = 32'h66666666;
        tick();
        checks++; if (id_valid !== 1'b0 || id_inst !== 32'd0) begin errors++; $display("FAIL rst_no_update got %b %h exp 0 0", id_valid, id_inst); end
        @(negedge clk) rst_n = 1'b1;
        inst_ack = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] exp_next;
        int          deliveries;
        int          n_fetch;
        int          n_bub;
        logic        p_stall, p_flush, p_redir, p_req, p_ack, p_valid;
        logic [31:0] p_rpc, p_addr, p_pc, p_pc4, p_inst;

        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0; inst_ack = 1'b0;
        tick();
        @(negedge clk) rst_n = 1'b1;
        exp_next = RST_PC; deliveries = 0; n_fetch = 0; n_bub = 0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            stall       = ($urandom_range(99) < 20);
            redirect    = ($urandom_range(99) < 7);
            redirect_pc = $urandom();
            flush       = (redirect || stall) ? ($urandom_range(1) == 1) : 1'b0;
            inst_ack    = inst_req && ($urandom_range(99) < 70);
            inst_rdata  = inst_ack ? mem_word(inst_addr) : $urandom();

            p_stall = stall; p_flush = flush; p_redir = redirect; p_rpc = redirect_pc;
            p_req = inst_req; p_ack = inst_ack; p_addr = inst_addr;
            p_valid = id_valid; p_pc = id_pc; p_pc4 = id_pc4; p_inst = id_inst;
            tick();

            if (p_flush) begin
                checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rnd_flush cyc %0d got %b exp 0", cyc, id_valid); end
                n_bub++;
            end else if (p_stall) begin
                checks++;
                if ({id_valid, id_pc, id_pc4, id_inst} !== {p_valid, p_pc, p_pc4, p_inst}) begin
                    errors++; $display("FAIL rnd_stall_hold cyc %0d got %b %h exp %b %h", cyc, id_valid, id_pc, p_valid, p_pc);
                end
            end else if (id_valid === 1'b1) begin
                checks++; if (id_pc !== exp_next) begin errors++; $display("FAIL rnd_order cyc %0d got %h exp %h", cyc, id_pc, exp_next); end
                checks++; if (id_pc4 !== exp_next + 32'd4) begin errors++; $display("FAIL rnd_pc4 cyc %0d got %h exp %h", cyc, id_pc4, exp_next + 32'd4); end
                checks++; if (id_inst !== mem_word(exp_next)) begin errors++; $display("FAIL rnd_inst cyc %0d got %h exp %h", cyc, id_inst, mem_word(exp_next)); end
                exp_next = exp_next + 32'd4;
                deliveries++;
                n_fetch++;
            end else begin
                n_bub++;
            end
            if (p_redir) exp_next = {p_rpc[31:2], 2'b00};

            if (p_req && !p_ack) begin
                checks++; if (inst_addr !== p_addr) begin errors++; $display("FAIL rnd_addr_stable cyc %0d got %h exp %h", cyc, inst_addr, p_addr); end
            end
            checks++; if (inst_addr[1:0] !== 2'b00) begin errors++; $display("FAIL rnd_addr_align cyc %0d got %h", cyc, inst_addr); end

            if (cyc % 100 == 99) begin
`ifdef IF_PERF_CNT_EN
                checks++; if (perf_fetch !== n_fetch) begin errors++; $display("FAIL rnd_perf_fetch got %0d exp %0d", perf_fetch, n_fetch); end
                checks++; if (perf_bubble !== n_bub) begin errors++; $display("FAIL rnd_perf_bubble got %0d exp %0d", perf_bubble, n_bub); end
`else
                checks++; if ({perf_fetch, perf_bubble} !== 64'd0) begin errors++; $display("FAIL rnd_perf_tied got %h %h exp 0", perf_fetch, perf_bubble); end
`endif
            end
        end
        checks++; if (deliveries < 200) begin errors++; $display("FAIL rnd_progress got %0d exp >=200", deliveries); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_drop();
        test_double_redirect();
        test_wrap_and_flush_stall();
        test_reset_midfetch();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
